// File: rtl/bram_fifo_pkg.sv
// rtl/bram_fifo_pkg.sv - shared constants and BRAM port bundle for the 512x32 FIFO controller
package bram_fifo_pkg;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int CW    = 10;

    // One port of a 512x32 dual-port BRAM macro, as driven by a controller
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          we;
        logic [DW-1:0] wem;
        logic          ce;
    } bram_port_t;
endpackage

// File: rtl/bram_fifo_obuf.sv
// rtl/bram_fifo_obuf.sv - 2-entry output skid buffer that absorbs the BRAM read latency
module bram_fifo_obuf
    import bram_fifo_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          cap,
    input  logic [DW-1:0] cap_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          pop,
    output logic [1:0]    ob_cnt
);
    logic [DW-1:0] ob0;
    logic [DW-1:0] ob1;
    logic          head;
    logic [1:0]    cnt;
    logic          wr_idx;

    // Capture never arrives with both entries full, so the free slot is head+cnt.
    assign wr_idx    = head ^ cnt[0];
    assign out_valid = (cnt != 2'd0);
    assign out_data  = head ? ob1 : ob0;
    assign pop       = out_valid && out_ready;
    assign ob_cnt    = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob0  <= '0;
            ob1  <= '0;
            head <= 1'b0;
            cnt  <= 2'd0;
        end else if (clr) begin
            ob0  <= '0;
            ob1  <= '0;
            head <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (cap && !wr_idx) ob0 <= cap_data;
            if (cap &&  wr_idx) ob1 <= cap_data;
            if (pop) head <= ~head;
            cnt <= cnt + 2'(cap) - 2'(pop);
        end
    end
endmodule

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - FIFO controller driving an external 512x32 dual-port BRAM
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
(
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] count,
    output logic [AW-1:0] A0,
    output logic [DW-1:0] D0,
    output logic          WE0,
    output logic [DW-1:0] WEM0,
    output logic          CE0,
    output logic [AW-1:0] A1,
    output logic [DW-1:0] D1,
    output logic          WE1,
    output logic [DW-1:0] WEM1,
    output logic          CE1,
    input  logic [DW-1:0] Q1
);
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   bram_cnt;
    logic [AW:0]   bram_cnt_nxt;
    logic          rd_pend;
    logic          push;
    logic          rd;
    logic          pop;
    logic [1:0]    ob_cnt;
    logic [2:0]    credit_used;
    logic [2:0]    credit_cap;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    bram_port_t    p0;
    bram_port_t    p1;

    assign in_ready = (bram_cnt < (AW+1)'(DEPTH)) && !clr;
    // Gate with RSTN so the macro sees no write while the controller is held in reset.
    assign push     = in_valid && in_ready && RSTN;

    // A pop this cycle frees an output slot in time for the read issued now,
    // which is what keeps the stream at one word per cycle.
    assign credit_used = {1'b0, ob_cnt} + {2'b00, rd_pend};
    assign credit_cap  = 3'd2 + {2'b00, pop};
    assign rd          = (bram_cnt != '0) && (credit_used < credit_cap) && !clr;

    assign bram_cnt_nxt = bram_cnt + (AW+1)'(push) - (AW+1)'(rd);
    assign count_nxt    = CW'(bram_cnt_nxt) + CW'(rd) + CW'(ob_cnt) + CW'(rd_pend) - CW'(pop);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            bram_cnt <= '0;
            rd_pend  <= 1'b0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            bram_cnt <= '0;
            rd_pend  <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (rd)   rd_ptr <= rd_ptr + AW'(1);
            bram_cnt <= bram_cnt_nxt;
            rd_pend  <= rd;
            count_q  <= count_nxt;
        end
    end

    bram_fifo_obuf u_obuf (
        .clk       (CLK),
        .rst_n     (RSTN),
        .clr       (clr),
        .cap       (rd_pend),
        .cap_data  (Q1),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .pop       (pop),
        .ob_cnt    (ob_cnt)
    );

    always_comb begin
        p0       = '0;
        p0.addr  = wr_ptr;
        p0.wdata = in_data;
        p0.we    = push;
        p0.wem   = '1;
        p0.ce    = push;
        p1       = '0;
        p1.addr  = rd_ptr;
        p1.ce    = rd;
    end

    assign A0    = p0.addr;
    assign D0    = p0.wdata;
    assign WE0   = p0.we;
    assign WEM0  = p0.wem;
    assign CE0   = p0.ce;
    assign A1    = p1.addr;
    assign D1    = p1.wdata;
    assign WE1   = p1.we;
    assign WEM1  = p1.wem;
    assign CE1   = p1.ce;
    assign count = count_q;
endmodule
